inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction fetch front-end that sits directly downstream of the AXI page cache and upstream of decode. It holds the fetch PC and drives the cache's read port (RDEN/RADDR/HIT_CHECK), then buffers returned words with their PCs in a small FIFO. It also handles redirects (branch/trap) without disturbing an in-flight cache refill. Throughput is one instruction per cycle on page hits.

## Interface
- DEPTH, 4: FIFO entries; power of two, 2..16.
- RESET_PC, 32'h0000_0000: fetch PC after reset; bits [1:0] must be 0.

- CLK  in  1  clock
- RST  in  1  reset, synchronous, active-high
- FLUSH  in  1  redirect request; discards queued and in-flight words
- NEW_PC  in  32  redirect target; sampled when FLUSH=1, bits [1:0] ignored (forced 0)
- RDEN  out  1  cache read enable
- RADDR  out  32  cache read address (= fetch_pc)
- HIT_CHECK  out  32  cache hit-check address (= fetch_pc)
- HIT_CHECK_RESULT  in  1  cache hit indication for HIT_CHECK
- RVALID  in  1  cache data valid, combinational from RDEN/RADDR same cycle
- RDATA  in  32  cache read data, valid when RVALID=1
- INST_VALID  out  1  FIFO head valid
- INST_PC  out  32  PC of head entry
- INST  out  32  instruction word of head entry
- INST_READY  in  1  decode consumes head when INST_VALID=1
- MISS_CYCLES  out  32  count of cycles with RDEN=1 and HIT_CHECK_RESULT=0; wraps at 2^32

## Operation
- State machine, 3 states: S_FETCH, S_MISS, S_MISS_REDIR.
- S_FETCH: RDEN = (count != DEPTH). If RDEN && RVALID, push {RADDR, RDATA} and fetch_pc += 4 (32-bit wrap). If RDEN && !RVALID, go to S_MISS.
- S_MISS: RDEN=1, RADDR held constant. The cache latches the refill page from RADDR when the refill finishes, so RADDR must not change until RVALID. On RVALID: push, fetch_pc += 4, go to S_FETCH. No space check is needed because the FIFO only drains in this state.
- S_MISS_REDIR: RDEN=1, RADDR held. On RVALID, drop the word (no push), set fetch_pc <= redirect_pc, and go to S_FETCH.
- FLUSH in S_FETCH with no miss starting this cycle:
  - FIFO cleared.
  - fetch_pc <= {NEW_PC[31:2], 2'b00}.
  - This cycle's push is suppressed.
- FLUSH in S_MISS, or in S_FETCH with RDEN && !RVALID:
  - FIFO cleared.
  - redirect_pc <= NEW_PC.
  - Go to S_MISS_REDIR.
- FLUSH in S_MISS_REDIR: FIFO stays empty; redirect_pc is overwritten (last redirect wins).
- FLUSH coincident with RVALID in S_MISS or S_MISS_REDIR: the word is dropped, fetch_pc <= NEW_PC, and the next state is S_FETCH.
- Pop: when INST_VALID && INST_READY && !FLUSH, the head is removed.
- Push and pop in the same cycle leave count unchanged.
- FLUSH has priority over pop.
- FIFO: circular buffer with rd/wr pointers of log2(DEPTH) bits and a count of log2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.
- INST_VALID = (count != 0). INST/INST_PC are read combinationally from the head entry.
- MISS_CYCLES increments each cycle RDEN && !HIT_CHECK_RESULT, including during S_MISS/S_MISS_REDIR.

## Timing
- Reset values:
  - state = S_FETCH, fetch_pc = RESET_PC, count = 0, pointers = 0, redirect_pc = 0.
  - INST_VALID = 0, MISS_CYCLES = 0.
  - RDEN forced 0 while RST=1.
- RST mid-miss aborts immediately. RADDR returns to RESET_PC, accepting that the cache refill page may be stale; the cache is reset by the same RST.
- First RDEN=1 occurs the first cycle after RST deasserts.
- Hit latency: word presented by the cache in cycle N appears as INST_VALID in cycle N+1.
- Sustained rate is 1 word/cycle while hitting and decode accepts.
- Full FIFO: RDEN=0 in S_FETCH, except that RDEN is never deasserted in S_MISS/S_MISS_REDIR.
- Redirect (no miss): FLUSH in cycle N produces RADDR = NEW_PC in cycle N+1; the first new instruction is valid in cycle N+2 on a hit.
- Redirect during miss: RADDR = old fetch_pc until the RVALID cycle, then NEW_PC the following cycle.

## Test plan
- Reset, RESET_PC=0x100, cache always hits with RDATA=RADDR^0xA5A5A5A5, INST_READY=1 -> INST_PC sequence 0x100, 0x104, 0x108…, one per cycle from cycle 2 after reset, INST matching the pattern; MISS_CYCLES=0.
- INST_READY=0 for 10 cycles, DEPTH=4 -> exactly 4 entries accepted, RDEN=0 once count=4. On release, PCs continue in order with no gap or duplicate.
- Miss at 0x1000 with RVALID held low for 40 cycles -> RADDR stays 0x1000 for all 40 cycles, MISS_CYCLES=40, then INST_PC=0x1000 is delivered.
- FLUSH with NEW_PC=0x2002 during steady hits and a full FIFO -> INST_VALID=0 the next cycle, RADDR=0x2000, first post-flush INST_PC=0x2000; no pre-flush PC appears afterwards.
- FLUSH (NEW_PC=0x3000), then FLUSH (NEW_PC=0x4000), both during a pending miss at 0x1000 -> RADDR held at 0x1000 until RVALID, the 0x1000 word is dropped, the next RADDR is 0x4000, and the first INST_PC is 0x4000.
- RST asserted in S_MISS -> next cycle all outputs are at reset values, RADDR=RESET_PC, and the FIFO is empty.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch front-end: drives the page-cache read port and queues
// returned words with their PCs for decode, handling redirects across refills.
module inst_fetch #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        FLUSH,
    input  logic [31:0] NEW_PC,
    output logic        RDEN,
    output logic [31:0] RADDR,
    output logic [31:0] HIT_CHECK,
    input  logic        HIT_CHECK_RESULT,
    input  logic        RVALID,
    input  logic [31:0] RDATA,
    output logic        INST_VALID,
    output logic [31:0] INST_PC,
    output logic [31:0] INST,
    input  logic        INST_READY,
    output logic [31:0] MISS_CYCLES
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_FETCH,
        S_MISS,
        S_MISS_REDIR
    } state_t;

    state_t         state_q, state_d;
    logic [31:0]    fetch_pc_q, fetch_pc_d;
    logic [31:0]    redir_pc_q, redir_pc_d;
    logic [31:0]    miss_q, miss_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [31:0]    pc_mem [DEPTH];
    logic [31:0]    inst_mem [DEPTH];

    logic        push;
    logic        pop;
    logic        clear;
    logic [31:0] new_pc;

    assign new_pc = {NEW_PC[31:2], 2'b00};

    // A refill in progress keeps RDEN high regardless of FIFO occupancy.
    assign RDEN = !RST && ((state_q != S_FETCH) || (count_q != CW'(DEPTH)));
    assign RADDR       = fetch_pc_q;
    assign HIT_CHECK   = fetch_pc_q;
    assign INST_VALID  = (count_q != '0);
    assign INST_PC     = pc_mem[rd_ptr_q];
    assign INST        = inst_mem[rd_ptr_q];
    assign MISS_CYCLES = miss_q;

    assign pop = INST_VALID && INST_READY && !FLUSH;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        redir_pc_d = redir_pc_q;
        push       = 1'b0;
        clear      = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                if (RDEN && !RVALID) begin
                    state_d = S_MISS;
                    if (FLUSH) begin
                        clear      = 1'b1;
                        redir_pc_d = new_pc;
                        state_d    = S_MISS_REDIR;
                    end
                end else if (FLUSH) begin
                    clear      = 1'b1;
                    fetch_pc_d = new_pc;
                end else if (RDEN) begin
                    push       = 1'b1;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                end
            end
            S_MISS: begin
                if (RVALID) begin
                    state_d = S_FETCH;
                    if (FLUSH) begin
                        clear      = 1'b1;
                        fetch_pc_d = new_pc;
                    end else begin
                        push       = 1'b1;
                        fetch_pc_d = fetch_pc_q + 32'd4;
                    end
                end else if (FLUSH) begin
                    clear      = 1'b1;
                    redir_pc_d = new_pc;
                    state_d    = S_MISS_REDIR;
                end
            end
            S_MISS_REDIR: begin
                clear = FLUSH;
                if (RVALID) begin
                    state_d    = S_FETCH;
                    fetch_pc_d = FLUSH ? new_pc : redir_pc_q;
                end else if (FLUSH) begin
                    redir_pc_d = new_pc;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            rd_ptr_d = rd_ptr_q + PW'(pop);
            wr_ptr_d = wr_ptr_q + PW'(push);
            count_d  = count_q + CW'(push) - CW'(pop);
        end
        miss_d = miss_q + 32'(RDEN && !HIT_CHECK_RESULT);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_FETCH;
            fetch_pc_q <= RESET_PC;
            redir_pc_q <= '0;
            miss_q     <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            redir_pc_q <= redir_pc_d;
            miss_q     <= miss_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            pc_mem[wr_ptr_q]   <= fetch_pc_q;
            inst_mem[wr_ptr_q] <= RDATA;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed vector table, hand-written miss/reset
// sequences, and random traffic against a queue-based reference model.
module tb_inst_fetch;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0100;
    localparam logic [31:0] PAT      = 32'hA5A5_A5A5;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        FLUSH = 1'b0;
    logic [31:0] NEW_PC = '0;
    logic        RDEN;
    logic [31:0] RADDR;
    logic [31:0] HIT_CHECK;
    logic        HIT_CHECK_RESULT;
    logic        RVALID;
    logic [31:0] RDATA;
    logic        INST_VALID;
    logic [31:0] INST_PC;
    logic [31:0] INST;
    logic        INST_READY = 1'b0;
    logic [31:0] MISS_CYCLES;
    logic        hit = 1'b1;

    // Cache stand-in: combinational data, word = address ^ pattern.
    assign HIT_CHECK_RESULT = hit;
    assign RVALID           = RDEN && hit;
    assign RDATA            = RADDR ^ PAT;

    inst_fetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .CLK(CLK),
        .RST(RST),
        .FLUSH(FLUSH),
        .NEW_PC(NEW_PC),
        .RDEN(RDEN),
        .RADDR(RADDR),
        .HIT_CHECK(HIT_CHECK),
        .HIT_CHECK_RESULT(HIT_CHECK_RESULT),
        .RVALID(RVALID),
        .RDATA(RDATA),
        .INST_VALID(INST_VALID),
        .INST_PC(INST_PC),
        .INST(INST),
        .INST_READY(INST_READY),
        .MISS_CYCLES(MISS_CYCLES)
    );

    always #5 CLK = ~CLK;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: queue of PCs awaiting decode plus refill bookkeeping.
    logic [31:0] mq[$];
    logic [31:0] m_pc;
    logic [31:0] m_redir;
    logic [31:0] m_miss;
    bit          m_wait;
    bit          m_drop;

    function automatic logic [31:0] al(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

    task automatic model_reset();
        mq.delete();
        m_pc    = RESET_PC;
        m_redir = '0;
        m_miss  = '0;
        m_wait  = 1'b0;
        m_drop  = 1'b0;
    endtask

    task automatic model_step(input bit f, input logic [31:0] np,
                              input bit rdy, input bit h);
        bit e_rden;
        bit popped;
        bit rv;
        e_rden = m_wait ? 1'b1 : (mq.size() != DEPTH);
        chk("rden", 32'(RDEN), 32'(e_rden));
        chk("raddr", RADDR, m_pc);
        chk("hit_check", HIT_CHECK, m_pc);
        chk("inst_valid", 32'(INST_VALID), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("inst_pc", INST_PC, mq[0]);
            chk("inst", INST, mq[0] ^ PAT);
        end
        chk("miss_cycles", MISS_CYCLES, m_miss);
        rv     = e_rden && h;
        popped = (mq.size() != 0) && rdy && !f;
        if (e_rden && !h) m_miss++;
        if (!m_wait) begin
            if (e_rden && !h) begin
                m_wait = 1'b1;
                m_drop = f;
                if (f) begin
                    mq.delete();
                    m_redir = al(np);
                end else if (popped) begin
                    void'(mq.pop_front());
                end
            end else if (f) begin
                mq.delete();
                m_pc = al(np);
            end else begin
                if (popped) void'(mq.pop_front());
                if (rv) begin
                    mq.push_back(m_pc);
                    m_pc += 32'd4;
                end
            end
        end else if (rv) begin
            m_wait = 1'b0;
            if (f) begin
                mq.delete();
                m_pc = al(np);
            end else if (m_drop) begin
                m_pc = m_redir;
            end else begin
                if (popped) void'(mq.pop_front());
                mq.push_back(m_pc);
                m_pc += 32'd4;
            end
            m_drop = 1'b0;
        end else if (f) begin
            mq.delete();
            m_drop  = 1'b1;
            m_redir = al(np);
        end else if (popped) begin
            void'(mq.pop_front());
        end
    endtask

    // One cycle: drive at negedge, check just after, before the next posedge.
    task automatic cyc(input bit f, input logic [31:0] np,
                       input bit rdy, input bit h);
        @(negedge CLK);
        RST        = 1'b0;
        FLUSH      = f;
        NEW_PC     = np;
        INST_READY = rdy;
        hit        = h;
        #1;
        model_step(f, np, rdy, h);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST        = 1'b1;
        FLUSH      = 1'b0;
        INST_READY = 1'b0;
        hit        = 1'b1;
        #1;
        chk("rden_in_reset", 32'(RDEN), 32'd0);
        @(negedge CLK);
        #1;
        chk("rden_in_reset2", 32'(RDEN), 32'd0);
        model_reset();
    endtask

    typedef struct {
        bit          f;
        logic [31:0] np;
        bit          rdy;
        bit          h;
        bit          e_rden;
        logic [31:0] e_raddr;
        bit          e_valid;
        logic [31:0] e_pc;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input bit f, input logic [31:0] np,
                                input bit rdy, input bit h, input bit er,
                                input logic [31:0] ea, input bit ev,
                                input logic [31:0] ep);
        vec_t v;
        v = '{f, np, rdy, h, er, ea, ev, ep};
        tbl.push_back(v);
    endfunction

    initial begin
        // Streaming hits, stall until full, release, then flush a full FIFO.
        add(0, 0, 1, 1, 1, 32'h100, 0, 0);
        add(0, 0, 1, 1, 1, 32'h104, 1, 32'h100);
        add(0, 0, 1, 1, 1, 32'h108, 1, 32'h104);
        add(0, 0, 1, 1, 1, 32'h10c, 1, 32'h108);
        add(0, 0, 0, 1, 1, 32'h110, 1, 32'h10c);
        add(0, 0, 0, 1, 1, 32'h114, 1, 32'h10c);
        add(0, 0, 0, 1, 1, 32'h118, 1, 32'h10c);
        for (int i = 0; i < 7; i++) add(0, 0, 0, 1, 0, 32'h11c, 1, 32'h10c);
        add(0, 0, 1, 1, 0, 32'h11c, 1, 32'h10c);
        add(0, 0, 1, 1, 1, 32'h11c, 1, 32'h110);
        add(0, 0, 1, 1, 1, 32'h120, 1, 32'h114);
        add(0, 0, 1, 1, 1, 32'h124, 1, 32'h118);
        add(0, 0, 1, 1, 1, 32'h128, 1, 32'h11c);
        add(0, 0, 0, 1, 1, 32'h12c, 1, 32'h120);
        add(1, 32'h2002, 0, 1, 0, 32'h130, 1, 32'h120);
        add(0, 0, 1, 1, 1, 32'h2000, 0, 0);
        add(0, 0, 1, 1, 1, 32'h2004, 1, 32'h2000);
        add(0, 0, 1, 1, 1, 32'h2008, 1, 32'h2004);

        repeat (2) @(posedge CLK);
        do_reset();
        foreach (tbl[i]) begin
            cyc(tbl[i].f, tbl[i].np, tbl[i].rdy, tbl[i].h);
            chk($sformatf("vec%0d_rden", i), 32'(RDEN), 32'(tbl[i].e_rden));
            chk($sformatf("vec%0d_raddr", i), RADDR, tbl[i].e_raddr);
            chk($sformatf("vec%0d_valid", i), 32'(INST_VALID), 32'(tbl[i].e_valid));
            if (tbl[i].e_valid) begin
                chk($sformatf("vec%0d_pc", i), INST_PC, tbl[i].e_pc);
                chk($sformatf("vec%0d_inst", i), INST, tbl[i].e_pc ^ PAT);
            end
            chk($sformatf("vec%0d_miss", i), MISS_CYCLES, 32'd0);
        end

        // Long miss at 0x1000: address held, 40 miss cycles counted.
        do_reset();
        cyc(1, 32'h1000, 1, 1);
        for (int i = 0; i < 40; i++) begin
            cyc(0, 0, 1, 0);
            chk("miss_hold_raddr", RADDR, 32'h1000);
        end
        cyc(0, 0, 1, 1);
        chk("miss_count40", MISS_CYCLES, 32'd40);
        chk("miss_fill_raddr", RADDR, 32'h1000);
        cyc(0, 0, 1, 1);
        chk("miss_deliver_valid", 32'(INST_VALID), 32'd1);
        chk("miss_deliver_pc", INST_PC, 32'h1000);

        // Two redirects during a miss: last one wins, refill word dropped.
        do_reset();
        cyc(1, 32'h1000, 1, 1);
        cyc(0, 0, 1, 0);
        cyc(1, 32'h3000, 1, 0);
        chk("redir1_raddr", RADDR, 32'h1000);
        cyc(0, 0, 1, 0);
        cyc(1, 32'h4000, 1, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 1);
        chk("redir_fill_raddr", RADDR, 32'h1000);
        cyc(0, 0, 1, 1);
        chk("redir_next_raddr", RADDR, 32'h4000);
        chk("redir_dropped", 32'(INST_VALID), 32'd0);
        cyc(0, 0, 1, 1);
        chk("redir_first_pc", INST_PC, 32'h4000);
        chk("redir_first_valid", 32'(INST_VALID), 32'd1);

        // Reset while a miss is pending.
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        do_reset();
        cyc(0, 0, 1, 1);
        chk("rst_miss_raddr", RADDR, RESET_PC);
        chk("rst_miss_valid", 32'(INST_VALID), 32'd0);
        chk("rst_miss_count", MISS_CYCLES, 32'd0);
        chk("rst_miss_rden", 32'(RDEN), 32'd1);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            bit          f;
            bit          r;
            bit          h;
            logic [31:0] np;
            f  = ($urandom_range(0, 99) < 6);
            r  = ($urandom_range(0, 99) < 65);
            h  = ($urandom_range(0, 99) < 75);
            np = $urandom;
            if ($urandom_range(0, 99) < 2) do_reset();
            cyc(f, np, r, h);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
